dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// Shares the single-port synchronous DataMemory between two requesters: the CPU load/store path (phase-4 accesses) and the host debug/loader port.
// Each request is sequenced through a fixed issue/wait/acknowledge FSM.
// Arbitration is fixed-priority CPU with a starvation guard for the debug port.
// Sits between the controller, the debug interface and the DataMemory instance.
// PARAMETERS
// ADDR_W    16  address width of both requesters and memory
// DATA_W    16  data word width
// READ_LAT  1   cycles from memory address/issue to valid mem_q (>=1)
// MAX_WAIT  4   consecutive lost arbitrations after which dbg wins a tie (>=1)
// PORTS
// clock        in   1        single clock; all state on rising edge
// reset        in   1        asynchronous, active-low reset
// cpu_req      in   1        CPU access request, level, held until cpu_ack
// cpu_we       in   1        1=store, 0=load; stable while cpu_req
// cpu_addr     in   ADDR_W   CPU address; stable while cpu_req
// cpu_wdata    in   DATA_W   CPU store data; stable while cpu_req
// cpu_ack      out  1        one-cycle completion pulse
// cpu_rdata    out  DATA_W   load data, valid in cpu_ack cycle, held after
// dbg_req      in   1        debug request, same rules as cpu_req
// dbg_we       in   1        debug write enable
// dbg_addr     in   ADDR_W   debug address
// dbg_wdata    in   DATA_W   debug write data
// dbg_ack      out  1        one-cycle completion pulse
// dbg_rdata    out  DATA_W   debug read data, valid in dbg_ack cycle, held after
// mem_address  out  ADDR_W   to DataMemory address
// mem_data     out  DATA_W   to DataMemory write data
// mem_wren     out  1        to DataMemory write enable
// mem_q        in   DATA_W   from DataMemory read data
// busy         out  1        1 in any state other than IDLE
// owner        out  1        0=CPU, 1=dbg; current/last granted requester
// BEHAVIOUR
// - Reset (async, while low): state IDLE, wait counter 0, all outputs 0; mem_wren drops immediately.
// - Reset mid-access: the access is abandoned and no ack is issued. A write in ISSUE may or may not have landed.
// - FSM: IDLE -> ISSUE -> (WAIT x READ_LAT, loads only) -> ACK -> IDLE.
// - IDLE: samples requests at each edge.
//   - Neither requesting: stay in IDLE.
//   - One requesting: grant it.
//   - Both requesting: grant CPU unless wait_cnt==MAX_WAIT, in which case grant dbg.
//   - On grant: latch owner, we, addr, wdata.
// - ISSUE: exactly one cycle.
//   - mem_address=addr, mem_data=wdata, mem_wren=we.
//   - Stores go to ACK next; loads go to WAIT.
// - WAIT: READ_LAT cycles, wren=0, address held. At the last WAIT edge, the rdata register of the owner loads mem_q.
// - ACK: exactly one cycle. Pulse owner's ack; return to IDLE. The ack is registered and does not depend combinationally on req.
// - Latency from the edge sampling req: store ack in cycle 2; load ack in cycle READ_LAT+2. Back-to-back throughput is one access per 3 (store) or READ_LAT+3 (load) cycles.
// - Requester drops req in its ack cycle; req still high in the next IDLE sample is a new request.
// - Outside ISSUE: mem_wren=0; mem_address/mem_data hold the last issued values (no glitch).
// - wait_cnt:
//   - +1 (saturating at MAX_WAIT) when dbg_req is high at an IDLE grant to CPU.
//   - Cleared on a dbg grant.
//   - Unchanged otherwise.
// - Request changes while not granted are ignored until the next IDLE sample. Request fields of the granted port are not re-read after the grant.
// - Non-owner rdata is never modified; ack is never asserted to the non-owner.
// - Simultaneous req and ack of the other port in the same cycle: the req is sampled at the following IDLE.
// STRUCTURE
// - Shared package dmem_arb_pkg: state enum (IDLE, ISSUE, WAIT, ACK), OWNER_CPU=0/OWNER_DBG=1, default widths.
// - Single flat module: FSM, latency counter and wait counter are inline; no sub-module is warranted.
// TESTING
// - Reset: hold reset low 3 cycles with both reqs high -> all outputs 0, no ack; release -> CPU granted first.
// - CPU store addr 0x0010 data 0xBEEF:
//   - mem_wren=1 for exactly one cycle with address 0x0010.
//   - cpu_ack in cycle 2; busy low after.
// - dbg load 0x0010 after the store, READ_LAT=1 -> dbg_ack in cycle 3 with dbg_rdata=0xBEEF; cpu_rdata unchanged.
// - Both reqs held continuously, MAX_WAIT=4 -> grant order CPU x4, dbg, CPU x4, dbg; wait_cnt never exceeds 4.
// - Reset asserted during WAIT of a load -> no ack ever for that load; busy=0 and mem_wren=0 immediately.
// - READ_LAT=3 load, with the CPU changing cpu_addr while waiting ->
//   - ack in cycle 5 with data of the originally latched address.
//   - dbg request raised mid-access is served next.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the DataMemory port arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_READ_LAT = 1;
  localparam int DEF_MAX_WAIT = 4;
endpackage

// File: rtl/dmem_port_arbiter.sv
// Two-requester (CPU / debug) front end for the single-port synchronous DataMemory.
// Fixed CPU priority with a lost-arbitration counter that lets debug win a tie.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = DEF_READ_LAT,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_q,
  output logic              o_busy,
  output logic              o_owner
);
  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t        r_state, w_next;
  logic              w_grant, w_grant_dbg, w_last_wait;
  logic              r_owner, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [LAT_W-1:0]  r_lat;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [DATA_W-1:0] r_cpu_rdata, r_dbg_rdata;

  assign w_last_wait = (r_state == WAIT) && (r_lat == LAT_W'(READ_LAT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_grant_dbg = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cpu_req || i_dbg_req) begin
          w_grant     = 1'b1;
          // Debug wins only when alone or once it has lost MAX_WAIT ties in a row.
          w_grant_dbg = i_dbg_req && (!i_cpu_req || r_wait_cnt == CNT_W'(MAX_WAIT));
          w_next      = ISSUE;
        end
      end
      ISSUE:   w_next = r_we ? ACK : WAIT;
      WAIT:    if (w_last_wait) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner     <= OWNER_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lat       <= '0;
      r_wait_cnt  <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_dbg ? OWNER_DBG : OWNER_CPU;
        r_we    <= w_grant_dbg ? i_dbg_we    : i_cpu_we;
        r_addr  <= w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
        r_wdata <= w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
        if (w_grant_dbg)
          r_wait_cnt <= '0;
        else if (i_dbg_req && r_wait_cnt != CNT_W'(MAX_WAIT))
          r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_state == ISSUE)     r_lat <= '0;
      else if (r_state == WAIT) r_lat <= r_lat + 1'b1;
      if (w_last_wait) begin
        if (r_owner == OWNER_DBG) r_dbg_rdata <= i_mem_q;
        else                      r_cpu_rdata <= i_mem_q;
      end
    end
  end

  // Address/data come straight from the grant latches so they hold between accesses.
  assign o_mem_address = r_addr;
  assign o_mem_data    = r_wdata;
  assign o_mem_wren    = (r_state == ISSUE) && r_we;
  assign o_cpu_ack     = (r_state == ACK) && (r_owner == OWNER_CPU);
  assign o_dbg_ack     = (r_state == ACK) && (r_owner == OWNER_DBG);
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_dbg_rdata   = r_dbg_rdata;
  assign o_busy        = (r_state != IDLE);
  assign o_owner       = r_owner;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_dmem_port_arbiter;
  localparam int MAXW = 4;
  localparam int RL_A = 1;

  logic clk = 1'b0;
  logic rst_n, mem_init;
  always #5 clk = ~clk;

  logic        a_cpu_req, a_cpu_we, a_cpu_ack, a_dbg_req, a_dbg_we, a_dbg_ack, a_mem_wren, a_busy, a_owner;
  logic [15:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata, a_dbg_addr, a_dbg_wdata, a_dbg_rdata;
  logic [15:0] a_mem_address, a_mem_data, a_mem_q;
  logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_dbg_req, b_dbg_we, b_dbg_ack, b_mem_wren, b_busy, b_owner;
  logic [15:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata, b_dbg_addr, b_dbg_wdata, b_dbg_rdata;
  logic [15:0] b_mem_address, b_mem_data, b_mem_q;

  dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(RL_A), .MAX_WAIT(MAXW)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(a_cpu_req), .i_cpu_we(a_cpu_we), .i_cpu_addr(a_cpu_addr), .i_cpu_wdata(a_cpu_wdata),
    .o_cpu_ack(a_cpu_ack), .o_cpu_rdata(a_cpu_rdata),
    .i_dbg_req(a_dbg_req), .i_dbg_we(a_dbg_we), .i_dbg_addr(a_dbg_addr), .i_dbg_wdata(a_dbg_wdata),
    .o_dbg_ack(a_dbg_ack), .o_dbg_rdata(a_dbg_rdata),
    .o_mem_address(a_mem_address), .o_mem_data(a_mem_data), .o_mem_wren(a_mem_wren),
    .i_mem_q(a_mem_q), .o_busy(a_busy), .o_owner(a_owner));

  dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3), .MAX_WAIT(MAXW)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(b_cpu_req), .i_cpu_we(b_cpu_we), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata(b_cpu_wdata),
    .o_cpu_ack(b_cpu_ack), .o_cpu_rdata(b_cpu_rdata),
    .i_dbg_req(b_dbg_req), .i_dbg_we(b_dbg_we), .i_dbg_addr(b_dbg_addr), .i_dbg_wdata(b_dbg_wdata),
    .o_dbg_ack(b_dbg_ack), .o_dbg_rdata(b_dbg_rdata),
    .o_mem_address(b_mem_address), .o_mem_data(b_mem_data), .o_mem_wren(b_mem_wren),
    .i_mem_q(b_mem_q), .o_busy(b_busy), .o_owner(b_owner));

  // Synchronous DataMemory stand-ins: latency 1 for u_dut, latency 3 for u_dut3.
  logic [15:0] mem_a [65536];
  logic [15:0] mem_b [65536];
  logic [15:0] b_p0, b_p1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) begin
        mem_a[i] <= 16'(i) ^ 16'h5A5A;
        mem_b[i] <= 16'(i) ^ 16'h5A5A;
      end
    end else begin
      if (a_mem_wren) mem_a[a_mem_address] <= a_mem_data;
      if (b_mem_wren) mem_b[b_mem_address] <= b_mem_data;
      a_mem_q <= mem_a[a_mem_address];
      b_p0    <= mem_b[b_mem_address];
      b_p1    <= b_p0;
      b_mem_q <= b_p1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;   // 0 = CPU, 1 = dbg
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_cyc;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tbl[8];
  logic [15:0] exp_cpu_rd, exp_dbg_rd;

  task automatic idle_all();
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
    a_dbg_req = 0; a_dbg_we = 0; a_dbg_addr = 0; a_dbg_wdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = 0; b_dbg_wdata = 0;
  endtask

  task automatic do_reset();
    idle_all();
    @(negedge clk); rst_n = 0; mem_init = 1;
    @(negedge clk); mem_init = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int cyc, wr;
    logic got;
    v = tbl[idx]; cyc = 0; wr = 0; got = 0;
    @(negedge clk);
    if (v.port) begin a_dbg_req = 1; a_dbg_we = v.we; a_dbg_addr = v.addr; a_dbg_wdata = v.wdata; end
    else        begin a_cpu_req = 1; a_cpu_we = v.we; a_cpu_addr = v.addr; a_cpu_wdata = v.wdata; end
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (a_mem_wren) begin
        wr++;
        chk($sformatf("vec%0d_waddr", idx), 32'(a_mem_address), 32'(v.addr));
        chk($sformatf("vec%0d_wdata", idx), 32'(a_mem_data), 32'(v.wdata));
      end
      if (c == 2 && !v.we) chk($sformatf("vec%0d_wait_addr", idx), 32'(a_mem_address), 32'(v.addr));
      chk($sformatf("vec%0d_other_ack", idx), 32'(v.port ? a_cpu_ack : a_dbg_ack), 32'd0);
      if ((v.port ? a_dbg_ack : a_cpu_ack) === 1'b1) begin
        got = 1; cyc = c; a_cpu_req = 0; a_dbg_req = 0;
      end
    end
    chk($sformatf("vec%0d_ack_cycle", idx), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("vec%0d_wren_pulses", idx), 32'(wr), v.we ? 32'd1 : 32'd0);
    if (!v.we) begin
      if (v.port) exp_dbg_rd = v.exp_rd;
      else        exp_cpu_rd = v.exp_rd;
    end
    chk($sformatf("vec%0d_cpu_rdata", idx), 32'(a_cpu_rdata), 32'(exp_cpu_rd));
    chk($sformatf("vec%0d_dbg_rdata", idx), 32'(a_dbg_rdata), 32'(exp_dbg_rd));
    @(negedge clk);
    chk($sformatf("vec%0d_busy_after", idx), 32'(a_busy), 32'd0);
  endtask

  // Transaction-level reference state for the randomized run.
  logic [15:0] ref_mem [65536];
  logic        m_active, m_owner, m_we;
  int          m_k, m_ackat, m_cnt;
  logic [15:0] m_addr, m_wdata, m_ld;
  logic [15:0] m_rd [2];

  initial begin
    int n, cyc, dcyc;
    logic got, dgot, e_ack, win_dbg;
    logic exp_pat [10];
    logic seen [10];

    exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 2, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b1, 16'h1234, 16'h0A0A, 2, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 3, 16'h0A0A};
    tbl[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 3, 16'hA5A5};
    tbl[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 2, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 3, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 3, 16'h1111};

    // Reset held with both requests pending.
    idle_all();
    rst_n = 0; mem_init = 1;
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h0020; a_cpu_wdata = 16'h1111;
    a_dbg_req = 1; a_dbg_we = 1; a_dbg_addr = 16'h0030; a_dbg_wdata = 16'h2222;
    @(negedge clk); mem_init = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_wren", 32'(a_mem_wren), 0);
      chk("rst_acks", 32'({a_cpu_ack, a_dbg_ack}), 0);
      chk("rst_owner", 32'(a_owner), 0);
      chk("rst_addr", 32'(a_mem_address), 0);
      chk("rst_rdata", 32'({a_cpu_rdata, a_dbg_rdata}), 0);
    end
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_owner", 32'(a_owner), 0);
    chk("post_rst_wren", 32'(a_mem_wren), 1);
    chk("post_rst_addr", 32'(a_mem_address), 32'h0020);
    @(negedge clk);
    chk("post_rst_cpu_ack", 32'(a_cpu_ack), 1);
    a_cpu_req = 0;
    @(negedge clk); @(negedge clk);
    chk("post_rst_dbg_owner", 32'(a_owner), 1);
    @(negedge clk);
    chk("post_rst_dbg_ack", 32'(a_dbg_ack), 1);
    a_dbg_req = 0;
    @(negedge clk);

    exp_cpu_rd = 0; exp_dbg_rd = 0;
    for (int i = 0; i < 8; i++) run_vec(i);

    // READ_LAT=3: CPU address changes while waiting, dbg request raised mid-access.
    @(negedge clk);
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 16'h0040;
    got = 0; dgot = 0; cyc = 0; dcyc = 0;
    for (int c = 1; c <= 20 && !dgot; c++) begin
      @(negedge clk);
      if (c == 2) begin
        b_cpu_addr = 16'h0041;
        b_dbg_req = 1; b_dbg_we = 0; b_dbg_addr = 16'h0041;
      end
      if (c == 3) chk("lat3_held_addr", 32'(b_mem_address), 32'h0040);
      if (b_cpu_ack === 1'b1 && !got) begin
        got = 1; cyc = c; b_cpu_req = 0;
        chk("lat3_cpu_rdata", 32'(b_cpu_rdata), 32'h5A1A);
      end
      if (b_dbg_ack === 1'b1) begin
        dgot = 1; dcyc = c; b_dbg_req = 0;
        chk("lat3_dbg_rdata", 32'(b_dbg_rdata), 32'h5A1B);
        chk("lat3_cpu_rdata_kept", 32'(b_cpu_rdata), 32'h5A1A);
      end
    end
    chk("lat3_cpu_ack_cycle", 32'(cyc), 5);
    chk("lat3_dbg_ack_cycle", 32'(dcyc), 11);

    // Both requests held: CPU x4, dbg, CPU x4, dbg.
    do_reset();
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h0100; a_cpu_wdata = 16'h0001;
    a_dbg_req = 1; a_dbg_we = 1; a_dbg_addr = 16'h0200; a_dbg_wdata = 16'h0002;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (a_cpu_ack === 1'b1 && n < 10) begin seen[n] = 0; n++; end
      if (a_dbg_ack === 1'b1 && n < 10) begin seen[n] = 1; n++; end
    end
    idle_all();
    chk("starve_count", 32'(n), 10);
    for (int i = 0; i < n; i++) chk($sformatf("starve_grant%0d", i), 32'(seen[i]), 32'(exp_pat[i]));

    // Reset during WAIT of a dbg load.
    @(negedge clk); @(negedge clk);
    a_dbg_req = 1; a_dbg_we = 0; a_dbg_addr = 16'h0010;
    @(negedge clk); @(negedge clk);
    chk("rwait_busy_before", 32'(a_busy), 1);
    #1 rst_n = 0;
    #1;
    chk("rwait_busy", 32'(a_busy), 0);
    chk("rwait_wren", 32'(a_mem_wren), 0);
    chk("rwait_acks", 32'({a_cpu_ack, a_dbg_ack}), 0);
    a_dbg_req = 0;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rwait_no_ack", 32'({a_cpu_ack, a_dbg_ack}), 0);
    end

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i) ^ 16'h5A5A;
    m_active = 0; m_owner = 0; m_we = 0; m_k = 0; m_ackat = 0; m_cnt = 0;
    m_addr = 0; m_wdata = 0; m_ld = 0; m_rd[0] = 0; m_rd[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      e_ack = m_active && (m_k == m_ackat);
      if (e_ack && !m_we) m_rd[m_owner] = m_ld;
      chk("rnd_cpu_ack", 32'(a_cpu_ack), 32'(e_ack && !m_owner));
      chk("rnd_dbg_ack", 32'(a_dbg_ack), 32'(e_ack && m_owner));
      chk("rnd_busy", 32'(a_busy), 32'(m_active));
      chk("rnd_owner", 32'(a_owner), 32'(m_owner));
      chk("rnd_wren", 32'(a_mem_wren), 32'(m_active && m_k == 1 && m_we));
      chk("rnd_addr", 32'(a_mem_address), 32'(m_addr));
      chk("rnd_data", 32'(a_mem_data), 32'(m_wdata));
      chk("rnd_cpu_rdata", 32'(a_cpu_rdata), 32'(m_rd[0]));
      chk("rnd_dbg_rdata", 32'(a_dbg_rdata), 32'(m_rd[1]));
      if (e_ack && !m_owner) a_cpu_req = 0;
      if (e_ack &&  m_owner) a_dbg_req = 0;
      if (!a_cpu_req && $urandom_range(0, 99) < 40) begin
        a_cpu_req = 1; a_cpu_we = 1'($urandom_range(0, 1));
        a_cpu_addr = 16'($urandom_range(0, 31)); a_cpu_wdata = 16'($urandom);
      end
      if (!a_dbg_req && $urandom_range(0, 99) < 40) begin
        a_dbg_req = 1; a_dbg_we = 1'($urandom_range(0, 1));
        a_dbg_addr = 16'($urandom_range(0, 31)); a_dbg_wdata = 16'($urandom);
      end
      if (m_active) begin
        if (m_k == m_ackat) m_active = 0;
        else                m_k++;
      end else if (a_cpu_req || a_dbg_req) begin
        win_dbg = a_dbg_req && (!a_cpu_req || m_cnt == MAXW);
        if (win_dbg)        m_cnt = 0;
        else if (a_dbg_req) m_cnt = (m_cnt < MAXW) ? m_cnt + 1 : MAXW;
        m_owner = win_dbg;
        m_we    = win_dbg ? a_dbg_we    : a_cpu_we;
        m_addr  = win_dbg ? a_dbg_addr  : a_cpu_addr;
        m_wdata = win_dbg ? a_dbg_wdata : a_cpu_wdata;
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_ld = ref_mem[m_addr];
        m_ackat  = m_we ? 2 : RL_A + 2;
        m_k      = 1;
        m_active = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
